// File: rtl/switch_sched.sv
// Two-requester round-robin scheduler feeding the nibble-swizzle datapath.
// One operand pair in flight; the result is held in a valid/ready output buffer.
module switch_sched #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_valid,
    input  logic [7:0]         a_x,
    input  logic [7:0]         a_y,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [7:0]         b_x,
    input  logic [7:0]         b_y,
    output logic               b_ready,
    output logic               o_valid,
    output logic [15:0]        o_data,
    output logic               o_src,
    input  logic               o_ready,
    output logic [COUNT_W-1:0] a_count,
    output logic [COUNT_W-1:0] b_count,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         x_q, x_d;
    logic [7:0]         y_q, y_d;
    logic               src_q, src_d;
    logic [15:0]        o_data_q, o_data_d;
    logic               o_valid_q, o_valid_d;
    logic               o_src_q, o_src_d;
    logic [COUNT_W-1:0] a_count_q, a_count_d;
    logic [COUNT_W-1:0] b_count_q, b_count_d;
    logic               prio_q, prio_d;

    logic               grant_a;
    logic               grant_b;
    logic [15:0]        swz;

    always_comb begin
        if (x_q[7] == y_q[7]) begin
            swz = {y_q[3:0], x_q[3:0], y_q[7:4], x_q[7:4]};
        end else begin
            swz = {x_q[7:4], y_q[7:4], x_q[3:0], y_q[3:0]};
        end
    end

    // A lone valid wins outright; prio only breaks ties.
    always_comb begin
        grant_a = a_valid && (!b_valid || !prio_q);
        grant_b = b_valid && !grant_a;
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        src_d     = src_q;
        o_data_d  = o_data_q;
        o_valid_d = o_valid_q;
        o_src_d   = o_src_q;
        a_count_d = a_count_q;
        b_count_d = b_count_q;
        prio_d    = prio_q;
        a_ready   = 1'b0;
        b_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_a || grant_b) begin
                    a_ready = rst_n && grant_a;
                    b_ready = rst_n && grant_b;
                    x_d     = grant_b ? b_x : a_x;
                    y_d     = grant_b ? b_y : a_y;
                    src_d   = grant_b;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                o_data_d  = swz;
                o_src_d   = src_q;
                o_valid_d = 1'b1;
                state_d   = HOLD;
            end
            HOLD: begin
                if (o_ready) begin
                    o_valid_d = 1'b0;
                    if (o_src_q) begin
                        b_count_d = b_count_q + COUNT_W'(1);
                    end else begin
                        a_count_d = a_count_q + COUNT_W'(1);
                    end
                    prio_d  = ~o_src_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            src_q     <= 1'b0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_src_q   <= 1'b0;
            a_count_q <= '0;
            b_count_q <= '0;
            prio_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            src_q     <= src_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_src_q   <= o_src_d;
            a_count_q <= a_count_d;
            b_count_q <= b_count_d;
            prio_q    <= prio_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_src   = o_src_q;
    assign a_count = a_count_q;
    assign b_count = b_count_q;
    assign busy    = (state_q != IDLE);

endmodule
